sprite_lbuf_writer: RTL

- Sprite line-buffer engine. It sits directly upstream of the 1024x8 dual-port sprite line buffer.
- It accepts sprite descriptors for the next scanline, fetches 4bpp pixel bytes from the registered-read sprite ROM, and writes the opaque pixels into the write bank.
- At the same time it scans the display bank at pixel rate, outputs each pixel, and clears it to 0 behind the beam.
- Banks swap on every LINE_START.

---
 rtl/sprite_lbuf_writer_pkg.sv | 28 ++
 rtl/sprite_lbuf_writer_if.sv | 21 ++
 rtl/sprite_lbuf_writer_scan_clear.sv | 41 ++++
 rtl/sprite_lbuf_writer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sprite_lbuf_writer_pkg.sv
// Shared definitions for the sprite line-buffer writer: fetch FSM encoding,
// line-buffer geometry and the sprite pixel placement rule.
package sprite_lb_pkg;

    localparam int LB_AW         = 10;
    localparam int LB_XW         = 9;
    localparam int SPR_W         = 16;
    localparam int BYTES_PER_ROW = 8;

    localparam logic [3:0] PEN_TRANSPARENT = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_LO   = 2'd2,
        ST_HI   = 2'd3
    } fetch_state_t;

    // Line x of sprite pixel p; bit 8 set means the pixel fell off the right edge.
    function automatic logic [LB_XW-1:0] pixel_x(input logic [7:0] spr_x,
                                                  input logic [3:0] p,
                                                  input logic       flip);
        logic [3:0] ofs;
        ofs = flip ? (4'd15 - p) : p;
        return {1'b0, spr_x} + {5'b0, ofs};
    endfunction

endpackage

// File: rtl/sprite_lbuf_writer_if.sv
// Sprite descriptor handshake between the sprite list scanner and the writer.
interface sprite_lbuf_writer_if #(
    parameter int CW = 8
);
    logic          spr_valid;
    logic          spr_ready;
    logic [7:0]    spr_x;
    logic [CW-1:0] spr_code;
    logic [3:0]    spr_col;
    logic          spr_flip;

    modport master (
        output spr_valid, spr_x, spr_code, spr_col, spr_flip,
        input  spr_ready
    );

    modport slave (
        input  spr_valid, spr_x, spr_code, spr_col, spr_flip,
        output spr_ready
    );
endinterface

// File: rtl/sprite_lbuf_writer_scan_clear.sv
// Display-bank scan port: reads one pixel per PCE, clears it behind the beam
// and presents it on pix_out three clocks after the PCE.
module lbuf_scan_clear
    import sprite_lb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pce,
    input  logic [LB_XW-1:0] hpos,
    input  logic             rbank,
    input  logic [7:0]       lb_dt1,
    output logic [LB_AW-1:0] lb_ad1,
    output logic             lb_re1,
    output logic             lb_we1,
    output logic [7:0]       lb_wd1,
    output logic [7:0]       pix_out
);

    assign lb_wd1 = 8'h00;

    // The address is frozen at the read cycle, so a bank swap during the
    // following clear cycle still clears the pixel that was read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_ad1  <= '0;
            lb_re1  <= 1'b0;
            lb_we1  <= 1'b0;
            pix_out <= 8'h00;
        end else begin
            lb_re1 <= pce && !lb_re1;
            if (pce && !lb_re1) begin
                lb_ad1 <= {rbank, hpos};
            end
            lb_we1 <= lb_re1;
            if (lb_we1) begin
                pix_out <= lb_dt1;
            end
        end
    end

endmodule

// File: rtl/sprite_lbuf_writer.sv
// Sprite line-buffer engine: fetches 4bpp sprite rows from ROM into the write
// bank while the scan port plays out and clears the display bank.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a descriptor; spr_ready high
//   ADDR    | rom_ad = {code,k} presented, ROM read in flight
//   LO      | rom_dt valid; write low nibble as pixel 2k
//   HI      | write high nibble as pixel 2k+1; next byte or back to IDLE
module sprite_lbuf_writer
    import sprite_lb_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pce,
    input  logic [LB_XW-1:0] hpos,
    input  logic             line_start,
    sprite_lbuf_writer_if.slave spr,
    output logic [CW+2:0]    rom_ad,
    input  logic [7:0]       rom_dt,
    output logic [LB_AW-1:0] lb_ad0,
    output logic             lb_we0,
    output logic [7:0]       lb_wd0,
    output logic [LB_AW-1:0] lb_ad1,
    output logic             lb_re1,
    output logic             lb_we1,
    output logic [7:0]       lb_wd1,
    input  logic [7:0]       lb_dt1,
    output logic [7:0]       pix_out,
    output logic             busy,
    output logic             overrun
);

    fetch_state_t     state;
    logic [2:0]       k;
    logic             wbank;
    logic             ready_q;
    logic [7:0]       d_x;
    logic [CW-1:0]    d_code;
    logic [3:0]       d_col;
    logic             d_flip;
    logic [3:0]       rom_hi;

    logic [3:0]       cur_nib;
    logic [3:0]       cur_p;
    logic [LB_XW-1:0] cur_xs;

    assign spr.spr_ready = ready_q;

    always_comb begin
        cur_nib = (state == ST_LO) ? rom_dt[3:0] : rom_hi;
        cur_p   = {k, (state == ST_HI)};
        cur_xs  = pixel_x(d_x, cur_p, d_flip);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            k       <= 3'd0;
            wbank   <= 1'b0;
            ready_q <= 1'b0;
            d_x     <= 8'h00;
            d_code  <= '0;
            d_col   <= 4'h0;
            d_flip  <= 1'b0;
            rom_hi  <= 4'h0;
            rom_ad  <= '0;
            lb_ad0  <= '0;
            lb_we0  <= 1'b0;
            lb_wd0  <= 8'h00;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            lb_we0  <= 1'b0;
            overrun <= 1'b0;
            if (line_start) begin
                wbank <= ~wbank;
            end

            // A sprite still in flight at the line boundary belongs to a
            // line that is already being displayed; drop it.
            if (line_start && state != ST_IDLE) begin
                state   <= ST_IDLE;
                ready_q <= 1'b1;
                busy    <= 1'b0;
                overrun <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        ready_q <= 1'b1;
                        if (spr.spr_valid && ready_q && !line_start) begin
                            d_x     <= spr.spr_x;
                            d_code  <= spr.spr_code;
                            d_col   <= spr.spr_col;
                            d_flip  <= spr.spr_flip;
                            k       <= 3'd0;
                            rom_ad  <= {spr.spr_code, 3'd0};
                            state   <= ST_ADDR;
                            ready_q <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        state <= ST_LO;
                    end
                    ST_LO: begin
                        rom_hi <= rom_dt[7:4];
                        lb_ad0 <= {wbank, cur_xs};
                        lb_wd0 <= {d_col, cur_nib};
                        lb_we0 <= (cur_nib != PEN_TRANSPARENT) && !cur_xs[LB_XW-1];
                        state  <= ST_HI;
                    end
                    ST_HI: begin
                        lb_ad0 <= {wbank, cur_xs};
                        lb_wd0 <= {d_col, cur_nib};
                        lb_we0 <= (cur_nib != PEN_TRANSPARENT) && !cur_xs[LB_XW-1];
                        if (k == 3'(BYTES_PER_ROW - 1)) begin
                            state   <= ST_IDLE;
                            ready_q <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            k      <= k + 3'd1;
                            rom_ad <= {d_code, k + 3'd1};
                            state  <= ST_ADDR;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    lbuf_scan_clear u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .pce     (pce),
        .hpos    (hpos),
        .rbank   (~wbank),
        .lb_dt1  (lb_dt1),
        .lb_ad1  (lb_ad1),
        .lb_re1  (lb_re1),
        .lb_we1  (lb_we1),
        .lb_wd1  (lb_wd1),
        .pix_out (pix_out)
    );

endmodule
